bj_resolve_predict_unit: RTL and testbench
==========================================

// Module: bj_resolve_predict_unit
// PURPOSE
//  Resolves branch/jump outcome in EX for XLEN-bit operands and registers the result for the PC-select mux.
//  Holds a 2-bit saturating-counter branch history table (BHT) read by IF for prediction and trained at resolve.
//  Flags mispredicts versus the prediction carried down the pipeline from IF; honours pipeline STALL/FLUSH.
// PARAMETERS
//  XLEN            32   operand / PC width
//  BHT_INDEX_BITS  6    log2 of BHT entries (64); index = PC[BHT_INDEX_BITS+1:2]
//  BHT_INIT        2'b01 reset value of every BHT counter (weakly not-taken)
// PORTS
//  CLK            in   1     clock, rising edge
//  RESET          in   1     asynchronous, active-low reset
//  STALL          in   1     hold output regs, block BHT update
//  FLUSH          in   1     kill instruction in EX
//  BJ_VALID       in   1     EX holds a valid instruction
//  BRANCH_JUMP    in   3     000 BEQ,001 BNE,010 NONE,011 JUMP,100 BLT,101 BGE,110 BLTU,111 BGEU
//  DATA1, DATA2   in   XLEN  compare operands (rs1, rs2)
//  EX_PC          in   XLEN  PC of instruction in EX (BHT update index)
//  EX_PRED_TAKEN  in   1     prediction made for it in IF
//  LOOKUP_PC      in   XLEN  IF-stage PC
//  LOOKUP_TAKEN   out  1     combinational: BHT[idx(LOOKUP_PC)][1]
//  PC_SEL_OUT     out  1     registered actual taken
//  MISPREDICT     out  1     registered actual != predicted
//  RESOLVE_VALID  out  1     registered: valid resolved branch/jump
// BEHAVIOUR
//  - Compare: eq = DATA1==DATA2; lt signed for 10x, unsigned for 11x.
//  - taken: BEQ eq; BNE !eq; BLT/BLTU lt; BGE/BGEU !lt; JUMP 1; NONE 0.
//  - act = BJ_VALID & code!=010. Latency 1: outputs reflect EX inputs sampled on previous rising edge.
//  - Edge priority: RESET > FLUSH > STALL > capture.
//    FLUSH: PC_SEL_OUT/MISPREDICT/RESOLVE_VALID <= 0; no BHT update (even if STALL high).
//    STALL: all output regs and BHT hold.
//    capture: RESOLVE_VALID<=act; PC_SEL_OUT<=act&taken; MISPREDICT<=act&(taken!=EX_PRED_TAKEN).
//  - BHT update on capture edge only when act and code is a conditional branch (not 011):
//    taken -> counter+1 saturating at 11; not taken -> counter-1 saturating at 00. JUMP never trains.
//  - States per entry: 00 SNT, 01 WNT, 10 WT, 11 ST; prediction = MSB.
//  - Same-cycle lookup and update of same index: LOOKUP_TAKEN shows pre-update value; new value next cycle.
//  - BJ_VALID=0 or code 010: outputs 0 after capture edge, BHT unchanged.
//  - RESET low (any time, incl. mid-stall): outputs 0 immediately; all BHT entries = BHT_INIT.
//  - LOOKUP_PC bits outside index range ignored; aliasing between PCs is accepted.
// CONFIGURATION
//  BJ_STATS_EN defined: adds outputs BR_COUNT out 32, MISS_COUNT out 32; on each capture edge
//   BR_COUNT+=act, MISS_COUNT+=act&mispredict; wrap modulo 2^32; cleared only by RESET; hold on STALL/FLUSH.
//  BJ_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 RESET low then high -> all outputs 0; LOOKUP_TAKEN=0 for every LOOKUP_PC (BHT_INIT=01).
//  2 BLT DATA1=32'hFFFF_FFFF, DATA2=1, pred 0 -> next edge PC_SEL_OUT=1, MISPREDICT=1; same as BLTU -> 0, 0.
//  3 BEQ at EX_PC=0x40 taken 3x -> BHT[16]: 01->10->11->11; LOOKUP_PC=0x40 gives 1 after first edge.
//  4 BNE 5 vs 5 with STALL=1 two cycles then released -> outputs hold prior value during stall, then PC_SEL_OUT=0.
//  5 JUMP with FLUSH=1 and STALL=1 -> outputs 0, BHT unchanged; JUMP pred 0 unflushed -> MISPREDICT=1.
//  6 BJ_STATS_EN: 10 branches, 3 mispredicted -> BR_COUNT=10, MISS_COUNT=3; preload 32'hFFFF_FFFF -> wraps to 0.

Source files
------------

// File: rtl/bj_resolve_predict_unit.sv
// -----------------------------------------------------------------------------
// bj_resolve_predict_unit
//
// Branch/jump resolution for the EX stage, plus the branch history table (BHT)
// that the IF stage reads for its predictions.
//
//   * The compare and taken decision are combinational on the EX operands.
//   * PC_SEL_OUT, MISPREDICT and RESOLVE_VALID are registered, so they have
//     one cycle of latency.
//   * The BHT holds 2-bit saturating counters: 00 SNT, 01 WNT, 10 WT, 11 ST.
//     The prediction is the counter MSB. A counter trains only on a captured
//     conditional branch. Jumps never train it.
//   * On each clock edge: RESET > FLUSH > STALL > capture.
//
// Optional feature macro: BJ_STATS_EN
//   When defined, the block adds BR_COUNT and MISS_COUNT. These are
//   free-running resolve and mispredict counters that wrap modulo 2^32.
//   Only RESET clears them.
// -----------------------------------------------------------------------------
module bj_resolve_predict_unit #(
    parameter int         XLEN           = 32,
    parameter int         BHT_INDEX_BITS = 6,
    parameter logic [1:0] BHT_INIT       = 2'b01
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic            BJ_VALID,
    input  logic [2:0]      BRANCH_JUMP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic [XLEN-1:0] EX_PC,
    input  logic            EX_PRED_TAKEN,
    input  logic [XLEN-1:0] LOOKUP_PC,
    output logic            LOOKUP_TAKEN,
    output logic            PC_SEL_OUT,
    output logic            MISPREDICT,
    output logic            RESOLVE_VALID
`ifdef BJ_STATS_EN
    ,
    output logic [31:0]     BR_COUNT,
    output logic [31:0]     MISS_COUNT
`endif
);

    localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;

    // Encoding of the branch/jump field that the decoder delivers.
    typedef enum logic [2:0] {
        BJ_BEQ  = 3'b000,
        BJ_BNE  = 3'b001,
        BJ_NONE = 3'b010,
        BJ_JUMP = 3'b011,
        BJ_BLT  = 3'b100,
        BJ_BGE  = 3'b101,
        BJ_BLTU = 3'b110,
        BJ_BGEU = 3'b111
    } bj_code_e;

    bj_code_e code;
    assign code = bj_code_e'(BRANCH_JUMP);

    // ---------------------------------------------------------------------
    // Compare and taken decision
    // ---------------------------------------------------------------------
    logic eq;
    logic lt_signed;
    logic lt_unsigned;
    logic lt;
    logic taken;

    assign eq          = (DATA1 == DATA2);
    assign lt_signed   = ($signed(DATA1) < $signed(DATA2));
    assign lt_unsigned = (DATA1 < DATA2);
    // Codes 11x compare unsigned and codes 10x compare signed.
    assign lt          = BRANCH_JUMP[1] ? lt_unsigned : lt_signed;

    // Decode the actual branch outcome from the code and the compare flags.
    // NOTE: every output of an always_comb gets a default first, so a missing case arm cannot infer a latch.
    always_comb begin
        taken = 1'b0;
        unique case (code)
            BJ_BEQ:           taken = eq;
            BJ_BNE:           taken = !eq;
            BJ_BLT,  BJ_BLTU: taken = lt;
            BJ_BGE,  BJ_BGEU: taken = !lt;
            BJ_JUMP:          taken = 1'b1;
            BJ_NONE:          taken = 1'b0;
            default:          taken = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Edge qualification
    // ---------------------------------------------------------------------
    logic act;          // a real branch or jump sits in EX
    logic capture_en;   // this edge captures (neither flushed nor stalled)
    logic train_en;     // this edge trains the BHT
    logic miss_now;     // resolved outcome disagrees with the IF prediction

    assign act        = BJ_VALID && (code != BJ_NONE);
    assign capture_en = !FLUSH && !STALL;
    assign train_en   = capture_en && act && (code != BJ_JUMP);
    assign miss_now   = (taken != EX_PRED_TAKEN);

    // ---------------------------------------------------------------------
    // Registered resolve outputs
    // ---------------------------------------------------------------------
    // A flush clears the result, a stall holds it, otherwise EX is captured.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PC_SEL_OUT    <= 1'b0;
            MISPREDICT    <= 1'b0;
            RESOLVE_VALID <= 1'b0;
        end else if (FLUSH) begin
            PC_SEL_OUT    <= 1'b0;
            MISPREDICT    <= 1'b0;
            RESOLVE_VALID <= 1'b0;
        end else if (!STALL) begin
            PC_SEL_OUT    <= act && taken;
            MISPREDICT    <= act && miss_now;
            RESOLVE_VALID <= act;
        end
    end

    // ---------------------------------------------------------------------
    // Branch history table
    // ---------------------------------------------------------------------
    logic [1:0]                bht [BHT_ENTRIES];
    logic [BHT_INDEX_BITS-1:0] ex_idx;
    logic [BHT_INDEX_BITS-1:0] lookup_idx;
    logic [1:0]                cnt_cur;
    logic [1:0]                cnt_next;

    // The word-aligned PC bits just above the byte offset select the entry.
    // Aliasing between PCs that share these bits is accepted.
    assign ex_idx     = EX_PC[BHT_INDEX_BITS+1:2];
    assign lookup_idx = LOOKUP_PC[BHT_INDEX_BITS+1:2];

    // IF reads the table combinationally. A same-cycle update is visible only
    // from the next cycle.
    assign LOOKUP_TAKEN = bht[lookup_idx][1];

    // Saturating increment on taken and saturating decrement on not taken.
    always_comb begin
        cnt_cur  = bht[ex_idx];
        cnt_next = cnt_cur;
        if (taken) begin
            if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'd1;
        end
    end

    // Reset every counter to its initial state, then train on captured
    // conditional branches.
    // NOTE: the table is built from flops, not a RAM macro, so it can take the async reset like any other state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= BHT_INIT;
            end
        end else if (train_en) begin
            bht[ex_idx] <= cnt_next;
        end
    end

    // The PC bits outside the index field are deliberately ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{EX_PC[XLEN-1:BHT_INDEX_BITS+2], EX_PC[1:0],
                              LOOKUP_PC[XLEN-1:BHT_INDEX_BITS+2], LOOKUP_PC[1:0]};

`ifdef BJ_STATS_EN
    // ---------------------------------------------------------------------
    // Resolve statistics
    // ---------------------------------------------------------------------
    logic [31:0] br_count_q;
    logic [31:0] miss_count_q;

    // Count resolves and mispredicts on capture edges only. Both counters
    // wrap modulo 2^32.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else if (capture_en) begin
            br_count_q   <= br_count_q + 32'(act);
            miss_count_q <= miss_count_q + 32'(act && miss_now);
        end
    end

    assign BR_COUNT   = br_count_q;
    assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_bj_resolve_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_bj_resolve_predict_unit
//
// Scoreboard bench. A reference model of the outputs and the BHT is advanced
// whenever a cycle is driven. The expected registered outputs are pushed to a
// queue and popped just after the edge that produces them. The BHT prediction
// is checked before every edge. Directed sequences add checks against fixed
// expected constants.
// Build with +define+BJ_STATS_EN to exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_bj_resolve_predict_unit;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        FLUSH;
    logic        BJ_VALID;
    logic [2:0]  BRANCH_JUMP;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [31:0] EX_PC;
    logic        EX_PRED_TAKEN;
    logic [31:0] LOOKUP_PC;
    logic        LOOKUP_TAKEN;
    logic        PC_SEL_OUT;
    logic        MISPREDICT;
    logic        RESOLVE_VALID;
`ifdef BJ_STATS_EN
    logic [31:0] BR_COUNT;
    logic [31:0] MISS_COUNT;
`endif

    bj_resolve_predict_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .FLUSH         (FLUSH),
        .BJ_VALID      (BJ_VALID),
        .BRANCH_JUMP   (BRANCH_JUMP),
        .DATA1         (DATA1),
        .DATA2         (DATA2),
        .EX_PC         (EX_PC),
        .EX_PRED_TAKEN (EX_PRED_TAKEN),
        .LOOKUP_PC     (LOOKUP_PC),
        .LOOKUP_TAKEN  (LOOKUP_TAKEN),
        .PC_SEL_OUT    (PC_SEL_OUT),
        .MISPREDICT    (MISPREDICT),
        .RESOLVE_VALID (RESOLVE_VALID)
`ifdef BJ_STATS_EN
        ,
        .BR_COUNT      (BR_COUNT),
        .MISS_COUNT    (MISS_COUNT)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    localparam logic [2:0] C_BEQ  = 3'b000;
    localparam logic [2:0] C_BNE  = 3'b001;
    localparam logic [2:0] C_NONE = 3'b010;
    localparam logic [2:0] C_JUMP = 3'b011;
    localparam logic [2:0] C_BLT  = 3'b100;
    localparam logic [2:0] C_BLTU = 3'b110;

    typedef struct packed {
        logic rv;
        logic ps;
        logic mp;
    } exp_t;

    exp_t        sb_q [$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state.
    logic [1:0]  m_bht [64];
    logic        m_rv, m_ps, m_mp;
    logic [31:0] m_br, m_miss;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_taken(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b010:  return 1'b0;
            3'b011:  return 1'b1;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return !($signed(a) < $signed(b));
            3'b110:  return a < b;
            default: return !(a < b);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_rv = 1'b0; m_ps = 1'b0; m_mp = 1'b0;
        m_br = '0; m_miss = '0;
    endtask

    // Drive one cycle, check the pre-edge prediction, update the model, and
    // compare the scoreboard entry just after the edge.
    task automatic step(input logic v, input logic [2:0] c, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] pc, input logic pred, input logic st, input logic fl,
                        input logic [31:0] lpc);
        logic t, a;
        exp_t e;
        @(negedge CLK);
        BJ_VALID = v; BRANCH_JUMP = c; DATA1 = d1; DATA2 = d2; EX_PC = pc;
        EX_PRED_TAKEN = pred; STALL = st; FLUSH = fl; LOOKUP_PC = lpc;
        #1;
        check("lookup_taken", 32'(LOOKUP_TAKEN), 32'(m_bht[lpc[7:2]][1]));
        t = model_taken(c, d1, d2);
        a = v && (c != C_NONE);
        if (fl) begin
            m_rv = 1'b0; m_ps = 1'b0; m_mp = 1'b0;
        end else if (!st) begin
            m_rv = a; m_ps = a && t; m_mp = a && (t != pred);
            m_br = m_br + 32'(a);
            m_miss = m_miss + 32'(a && (t != pred));
            if (a && c != C_JUMP) begin
                if (t && m_bht[pc[7:2]] != 2'b11) m_bht[pc[7:2]] = m_bht[pc[7:2]] + 2'd1;
                else if (!t && m_bht[pc[7:2]] != 2'b00) m_bht[pc[7:2]] = m_bht[pc[7:2]] - 2'd1;
            end
        end
        sb_q.push_back(exp_t'{rv: m_rv, ps: m_ps, mp: m_mp});
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("resolve_valid", 32'(RESOLVE_VALID), 32'(e.rv));
            check("pc_sel_out",    32'(PC_SEL_OUT),    32'(e.ps));
            check("mispredict",    32'(MISPREDICT),    32'(e.mp));
        end
`ifdef BJ_STATS_EN
        check("br_count",   BR_COUNT,   m_br);
        check("miss_count", MISS_COUNT, m_miss);
`endif
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        logic [31:0] pcs [4];
        pcs[0] = 32'h0000_0040; pcs[1] = 32'h0000_0044;
        pcs[2] = 32'h0000_1040; pcs[3] = 32'h0000_0100;

        RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0; BJ_VALID = 1'b0;
        BRANCH_JUMP = C_NONE; DATA1 = '0; DATA2 = '0; EX_PC = '0;
        EX_PRED_TAKEN = 1'b0; LOOKUP_PC = '0;
        model_reset();

        // 1: reset state, with every table entry predicting not taken
        #2;
        check("rst_pc_sel",    32'(PC_SEL_OUT),    32'd0);
        check("rst_mispred",   32'(MISPREDICT),    32'd0);
        check("rst_res_valid", 32'(RESOLVE_VALID), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 64; i++) begin
            LOOKUP_PC = {$urandom_range(0, 16'hFFFF), 8'h00} | 32'(i << 2) | 32'($urandom_range(0, 3));
            #1;
            check("rst_lookup", 32'(LOOKUP_TAKEN), 32'd0);
        end

        // 2: signed versus unsigned less-than
        step(1, C_BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 0, 0, 0, 32'h200);
        check("blt_pc_sel",  32'(PC_SEL_OUT), 32'd1);
        check("blt_mispred", 32'(MISPREDICT), 32'd1);
        step(1, C_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 0, 0, 0, 32'h200);
        check("bltu_pc_sel",  32'(PC_SEL_OUT), 32'd0);
        check("bltu_mispred", 32'(MISPREDICT), 32'd0);

        // 3: train index 16 up to saturation, then back down
        for (int i = 0; i < 3; i++) begin
            step(1, C_BEQ, 32'd7, 32'd7, 32'h40, 0, 0, 0, 32'h40);
            check("bht16_up", 32'(LOOKUP_TAKEN), 32'd1);
        end
        step(1, C_BEQ, 32'd7, 32'd8, 32'h40, 1, 0, 0, 32'h40);
        check("bht16_sat_dn1", 32'(LOOKUP_TAKEN), 32'd1);
        step(1, C_BEQ, 32'd7, 32'd8, 32'h40, 1, 0, 0, 32'h40);
        check("bht16_sat_dn2", 32'(LOOKUP_TAKEN), 32'd0);
        LOOKUP_PC = 32'hABC0_1040;
        #1;
        check("alias_lookup", 32'(LOOKUP_TAKEN), 32'd0);

        // 4: a stall holds the previous result, then the BNE resolves
        step(1, C_BEQ, 32'd3, 32'd3, 32'h80, 1, 0, 0, 32'h80);
        step(1, C_BNE, 32'd5, 32'd5, 32'h80, 0, 1, 0, 32'h80);
        check("stall_hold1", 32'(PC_SEL_OUT), 32'd1);
        step(1, C_BNE, 32'd5, 32'd5, 32'h80, 0, 1, 0, 32'h80);
        check("stall_hold2", 32'(PC_SEL_OUT), 32'd1);
        step(1, C_BNE, 32'd5, 32'd5, 32'h80, 0, 0, 0, 32'h80);
        check("bne_release_ps", 32'(PC_SEL_OUT),    32'd0);
        check("bne_release_rv", 32'(RESOLVE_VALID), 32'd1);

        // 5: flush beats stall, flushed branches do not train, jumps never train
        step(1, C_JUMP, 32'd0, 32'd0, 32'hC0, 0, 1, 1, 32'hC0);
        check("flush_ps", 32'(PC_SEL_OUT),    32'd0);
        check("flush_rv", 32'(RESOLVE_VALID), 32'd0);
        step(1, C_BEQ, 32'd1, 32'd1, 32'hC0, 0, 0, 1, 32'hC0);
        step(1, C_BEQ, 32'd1, 32'd1, 32'hC0, 0, 0, 1, 32'hC0);
        check("flush_no_train", 32'(LOOKUP_TAKEN), 32'd0);
        for (int i = 0; i < 3; i++) step(1, C_JUMP, 32'd1, 32'd2, 32'hC0, 0, 0, 0, 32'hC0);
        check("jump_ps",       32'(PC_SEL_OUT),   32'd1);
        check("jump_mispred",  32'(MISPREDICT),   32'd1);
        check("jump_no_train", 32'(LOOKUP_TAKEN), 32'd0);

        // Invalid and NONE slots clear the outputs and leave the table alone.
        step(0, C_BEQ, 32'd1, 32'd1, 32'hC0, 1, 0, 0, 32'hC0);
        check("invalid_rv", 32'(RESOLVE_VALID), 32'd0);
        step(1, C_NONE, 32'd1, 32'd1, 32'hC0, 1, 0, 0, 32'hC0);
        check("none_mp", 32'(MISPREDICT), 32'd0);

        // Asynchronous reset in the middle of a stall
        step(1, C_BEQ, 32'd9, 32'd9, 32'h40, 0, 0, 0, 32'h40);
        step(1, C_BEQ, 32'd9, 32'd9, 32'h40, 0, 0, 0, 32'h40);
        check("pre_rst_lookup", 32'(LOOKUP_TAKEN), 32'd1);
        @(negedge CLK);
        STALL = 1'b1;
        #2;
        RESET = 1'b0;
        #1;
        check("async_rst_ps",     32'(PC_SEL_OUT),   32'd0);
        check("async_rst_lookup", 32'(LOOKUP_TAKEN), 32'd0);
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
                 32'($urandom_range(0, 3)) - 32'd1, 32'($urandom_range(0, 3)) - 32'd1,
                 pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 pcs[$urandom_range(0, 3)]);
        end

`ifdef BJ_STATS_EN
        // 6: 10 branches with 3 mispredicts, then the counter wraps
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1, C_BEQ, 32'd4, 32'd4, 32'h300, (i >= 3), 0, 0, 32'h300);
        check("stats_br10",  BR_COUNT,   32'd10);
        check("stats_miss3", MISS_COUNT, 32'd3);
        @(negedge CLK);
        force dut.br_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_count_q;
        m_br = 32'hFFFF_FFFF;
        step(1, C_JUMP, 32'd0, 32'd0, 32'h300, 1, 0, 0, 32'h300);
        check("stats_wrap", BR_COUNT, 32'd0);
`else
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
